mem_arbiter: RTL
================

# mem_arbiter

Arbiter that shares one single-port unified instruction/data memory between the pipelined MIPS core's fetch stage (IF) and its memory stage (MEM). It grants one requester at a time and holds the other stalled. Contention alternates between the two so neither starves. A bounded wait on the memory acknowledge turns a hung memory into an error instead of a deadlocked pipeline.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 16, max cycles in a busy state without mem_ack before abort (≥2)
- ERR_DATA, 32'hDEADBEEF, read data returned on timeout

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  registered fetch data; held until next IF completion
- if_ready  out  1  one-cycle completion pulse for IF
- dm_req  in  1  data request; held until dm_ready
- dm_we  in  1  1 = write, 0 = read; stable while dm_req
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  registered load data; held until next DM read completion
- dm_ready  out  1  one-cycle completion pulse for DM
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  dm_req & ~dm_ready (combinational)
- mem_en  out  1  memory access active
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack
- mem_ack  in  1  memory completion; any latency ≥0 cycles after mem_en rises
- err  out  1  one-cycle pulse on timeout abort

## Operation
- States:
  - IDLE
  - BUSY_IF
  - BUSY_DM
- Masking: in IDLE, effective requests are if_req & ~if_ready and dm_req & ~dm_ready. A requester whose ready pulse is active that cycle is never regranted in the same cycle.
- Grant rule in IDLE:
  - One effective request: grant it.
  - Both: grant the port not in last_grant.
  - last_grant resets to IF, so DM wins the first contention.
  - Update last_grant on every grant.
- On grant, register mem_addr, mem_we and mem_wdata from the granted port. IF grants force mem_we=0 and mem_wdata=0.
- mem_en=1 exactly while in a BUSY state; mem_we=1 only in BUSY_DM with latched dm_we=1.
- In BUSY_x with mem_ack=1:
  - Go to IDLE.
  - Next cycle, x_ready=1.
  - For reads, x_rdata ← mem_rdata. DM writes leave dm_rdata unchanged.
- Timeout: the wait counter clears on grant and increments each BUSY cycle without mem_ack. When it reaches TIMEOUT-1 with no ack:
  - Go to IDLE.
  - Next cycle, x_ready=1 and err=1.
  - For reads, x_rdata ← ERR_DATA.
- mem_ack outside BUSY states is ignored.
- ready and err are registered and are never high for more than one consecutive cycle. if_ready and dm_ready are never high together.

## Timing
- Reset values:
  - State IDLE; last_grant=IF; counter 0.
  - mem_en, mem_we, if_ready, dm_ready, err = 0.
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0.
- Reset mid-transaction: the next cycle is IDLE with all of the above. The in-flight access is abandoned and no ready pulse is issued for it.
- Latency, uncontended, mem_ack in the first BUSY cycle:
  - Request seen in IDLE at cycle N.
  - mem_en=1 at N+1.
  - x_ready=1 at N+2.
- Each extra memory wait cycle adds one cycle.
- Back-to-back: the ready cycle is an IDLE cycle. The other port's pending request is granted in that same cycle, with mem_en at the next cycle. The minimum gap between accesses is one mem_en-low cycle.
- Requester rule: on the edge after x_ready is high, deassert x_req or present a new request.
- Timeout abort: err and ready assert TIMEOUT+1 cycles after the grant cycle.

## Test plan
- Uncontended IF read: if_req=1, if_addr=0x0000_0004, mem_ack=1 with mem_rdata=0x2008_0005 in the first BUSY cycle.
  - mem_en high at cycle 1.
  - if_ready pulse at cycle 2 with if_rdata=0x2008_0005.
  - stall_if high at cycles 0–1.
- Simultaneous requests after reset: if_req=1 and dm_req=1 (read 0x10) at cycle 0, memory acks immediately.
  - DM is granted first: dm_ready at cycle 2.
  - IF is granted in cycle 2: if_ready at cycle 4.
  - stall_if high through cycle 3.
- Sustained contention: both requests reasserted after every completion for 6 accesses.
  - Grants strictly alternate DM, IF, DM, IF, DM, IF.
  - if_ready and dm_ready never overlap.
- DM write: dm_we=1, addr 0x20, wdata 0x0000_00AA, memory acks after 2 wait cycles.
  - mem_we=1 with mem_wdata=0xAA for 3 cycles.
  - dm_ready at cycle 4.
  - dm_rdata keeps its previous value.
- Timeout: IF read with mem_ack tied low, TIMEOUT=16.
  - mem_en high cycles 1–16.
  - At cycle 17: err=1, if_ready=1, if_rdata=0xDEADBEEF.
  - A following DM request is serviced normally.
- Reset mid-access: assert rst in the 2nd BUSY_DM cycle, then assert mem_ack after reset.
  - All outputs are at reset values the next cycle.
  - No dm_ready pulse occurs.
  - The late mem_ack is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between the IF and MEM stages.
// Contention alternates between ports, and a bounded wait on mem_ack aborts hung accesses.
module mem_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t           state, state_n;
    logic             last_dm;
    logic             we_q;
    logic [CNT_W-1:0] cnt;
    logic             eff_if, eff_dm;
    logic             grant_if, grant_dm;
    logic             done, abort;

    // A port whose ready pulse is live this cycle has already been served.
    assign eff_if    = if_req & ~if_ready;
    assign eff_dm    = dm_req & ~dm_ready;
    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;
    assign mem_en    = (state != IDLE);
    assign mem_we    = (state == BUSY_DM) & we_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        grant_if = 1'b0;
        grant_dm = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        case (state)
            IDLE: begin
                if (eff_if && eff_dm) begin
                    grant_dm = ~last_dm;
                    grant_if = last_dm;
                end else begin
                    grant_dm = eff_dm;
                    grant_if = eff_if;
                end
                if (grant_dm)      state_n = BUSY_DM;
                else if (grant_if) state_n = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    done    = 1'b1;
                    state_n = IDLE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_dm   <= 1'b0;
            we_q      <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
            err       <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
            if (grant_dm) begin
                last_dm   <= 1'b1;
                we_q      <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                cnt       <= '0;
            end else if (grant_if) begin
                last_dm   <= 1'b0;
                we_q      <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                cnt       <= '0;
            end else if (mem_en && !done && !abort) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (done || abort) begin
                err <= abort;
                if (state == BUSY_IF) begin
                    if_ready <= 1'b1;
                    if_rdata <= done ? mem_rdata : ERR_DATA;
                end else begin
                    dm_ready <= 1'b1;
                    if (!we_q) dm_rdata <= done ? mem_rdata : ERR_DATA;
                end
            end
        end
    end

endmodule
